// File: rtl/fishing_pkg.sv
// Shared types and per-level geometry helpers for the fishing game controller.
package fishing_pkg;

    typedef enum logic [1:0] {
        ST_FISH   = 2'd0,
        ST_CATCH  = 2'd1,
        ST_ESCAPE = 2'd2,
        ST_WIN    = 2'd3
    } game_state_t;

    localparam int PULL_BITS = 4;

    // Reel strength nibble to per-tick pull distance.
    function automatic logic [2:0] pull_step(input logic [PULL_BITS-1:0] n);
        if (n >= 4'd10)
            return 3'd4;
        else if (n == 4'd9)
            return 3'd1;
        return 3'd0;
    endfunction

    function automatic int fish_h_for_level(input int k);
        int h;
        h = 10 >> k;
        return (h < 1) ? 1 : h;
    endfunction

    function automatic int hit_w_for_level(input int k);
        int w;
        w = 15 - 5 * k;
        return (w < 3) ? 3 : w;
    endfunction

    function automatic int fish_y_for_level(input int k, input int y0, input int y_step);
        return y0 - k * y_step;
    endfunction

endpackage

// File: rtl/fishing_game_ctrl_spawner.sv
// Spawn timer and fish x motion: waits for held moves, then swims left and wraps.
module fish_spawner
    import fishing_pkg::*;
#(
    parameter int CW           = 10,
    parameter int SPAWN_DELAY  = 400,
    parameter int FISH_X_START = 798,
    parameter int FISH_X_END   = 144
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          active,
    input  logic          move_held,
    input  logic          reload,
    input  logic          track,
    input  logic [CW-1:0] track_x,
    output logic [CW-1:0] fish_x
);

    localparam int TW = $clog2(SPAWN_DELAY + 1);
    localparam logic [TW-1:0] DELAY   = TW'(SPAWN_DELAY);
    localparam logic [CW-1:0] X_START = CW'(FISH_X_START);
    localparam logic [CW-1:0] X_WRAP  = CW'(FISH_X_END + 1);

    logic [TW-1:0] timer;

    // Reload beats tracking, which beats normal swimming.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer  <= '0;
            fish_x <= X_START;
        end else if (tick) begin
            if (reload) begin
                timer  <= '0;
                fish_x <= X_START;
            end else if (track) begin
                fish_x <= track_x;
            end else if (active) begin
                if (timer >= DELAY) begin
                    if (fish_x <= X_WRAP) begin
                        fish_x <= X_START;
                        timer  <= '0;
                    end else begin
                        fish_x <= fish_x - CW'(2);
                    end
                end else if (move_held) begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fishing_game_ctrl.sv
// Fishing game FSM: rod/line/fish coordinates, level progression, score and escape timeout.
module fishing_game_ctrl
    import fishing_pkg::*;
#(
    parameter int NUM_LEVELS   = 4,
    parameter int CW           = 10,
    parameter int REEL_W       = 9,
    parameter int ROD_X_MIN    = 312,
    parameter int ROD_X_MAX    = 798,
    parameter int ROD_X_RESET  = 450,
    parameter int SURFACE_Y    = 155,
    parameter int TOP_Y        = 106,
    parameter int FISH_X_START = 798,
    parameter int FISH_X_END   = 144,
    parameter int FISH_Y0      = 470,
    parameter int FISH_Y_STEP  = 90,
    parameter int SPAWN_DELAY  = 400,
    parameter int ESCAPE_TICKS = 120,
    parameter int SCORE_W      = 8,
    localparam int LW          = $clog2(NUM_LEVELS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               up,
    input  logic               left,
    input  logic               right,
    input  logic [REEL_W-1:0]  reel,
    output logic [CW-1:0]      rod_x,
    output logic [CW-1:0]      line_y,
    output logic [CW-1:0]      fish_x,
    output logic [CW-1:0]      fish_y,
    output logic [CW-1:0]      fish_h,
    output logic [LW-1:0]      level,
    output logic [1:0]         game_state,
    output logic               fish_visible,
    output logic               win_pulse,
    output logic [SCORE_W-1:0] score
);

    localparam int EW = $clog2(ESCAPE_TICKS);
    localparam logic [EW-1:0] ESC_LAST   = EW'(ESCAPE_TICKS - 1);
    localparam logic [LW-1:0] LAST_LEVEL = LW'(NUM_LEVELS - 1);
    localparam logic [CW-1:0] ROD_MIN    = CW'(ROD_X_MIN);
    localparam logic [CW-1:0] ROD_MAX    = CW'(ROD_X_MAX);
    localparam logic [CW-1:0] SURF       = CW'(SURFACE_Y);
    localparam logic [CW-1:0] TOP        = CW'(TOP_Y);

    game_state_t   state;
    logic [EW-1:0] esc_cnt;
    logic [2:0]    step;
    logic [CW-1:0] step_cw;
    logic [CW-1:0] hit_w;
    logic [CW-1:0] line_diff;
    logic [CW:0]   hit_right;
    logic          hit;
    logic [CW-1:0] rod_next;
    logic [CW-1:0] line_next;
    logic [CW-1:0] cur_level_y;
    logic [CW-1:0] next_level_y;
    logic [CW-1:0] next_level_h;
    logic          landed;
    logic          move_held;
    logic          reload;
    logic          unused_reel;

    assign step        = pull_step(reel[REEL_W-1 -: PULL_BITS]);
    assign step_cw     = CW'(step);
    assign unused_reel = ^reel[REEL_W-PULL_BITS-1:0];
    assign move_held   = left | right;
    assign landed      = (fish_y < TOP);
    assign game_state  = state;

    // Spawner is restarted on every level reload: level-up landing, escape, or replay from WIN.
    assign reload = (state == ST_ESCAPE)
                  | ((state == ST_CATCH) & landed & (level != LAST_LEVEL))
                  | ((state == ST_WIN) & move_held);

    always_comb begin
        hit_w        = CW'(hit_w_for_level(int'(level)));
        cur_level_y  = CW'(fish_y_for_level(int'(level), FISH_Y0, FISH_Y_STEP));
        next_level_y = CW'(fish_y_for_level(int'(level) + 1, FISH_Y0, FISH_Y_STEP));
        next_level_h = CW'(fish_h_for_level(int'(level) + 1));
        hit_right    = {1'b0, fish_x} + {1'b0, hit_w};
        line_diff    = (line_y >= fish_y) ? (line_y - fish_y) : (fish_y - line_y);
        hit          = up && (rod_x >= fish_x) && ({1'b0, rod_x} <= hit_right)
                       && (line_diff <= fish_h);

        rod_next = rod_x;
        if (right)
            rod_next = ({1'b0, rod_x} + (CW+1)'(3) >= {1'b0, ROD_MAX}) ? ROD_MAX : rod_x + CW'(3);
        else if (left)
            rod_next = ({1'b0, rod_x} <= {1'b0, ROD_MIN} + (CW+1)'(3)) ? ROD_MIN : rod_x - CW'(3);

        line_next = ({1'b0, line_y} + (CW+1)'(4) >= {1'b0, fish_y}) ? fish_y : line_y + CW'(4);
    end

    fish_spawner #(
        .CW           (CW),
        .SPAWN_DELAY  (SPAWN_DELAY),
        .FISH_X_START (FISH_X_START),
        .FISH_X_END   (FISH_X_END)
    ) u_spawner (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .active    (state == ST_FISH),
        .move_held (move_held),
        .reload    (reload),
        .track     (state == ST_CATCH),
        .track_x   (rod_x),
        .fish_x    (fish_x)
    );

    // win_pulse clears on every clock; everything else only moves on tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_FISH;
            rod_x        <= CW'(ROD_X_RESET);
            line_y       <= SURF;
            fish_y       <= CW'(FISH_Y0);
            fish_h       <= CW'(fish_h_for_level(0));
            level        <= '0;
            score        <= '0;
            esc_cnt      <= '0;
            fish_visible <= 1'b1;
            win_pulse    <= 1'b0;
        end else begin
            win_pulse <= 1'b0;
            if (tick) begin
                unique case (state)
                    ST_FISH: begin
                        rod_x  <= rod_next;
                        line_y <= line_next;
                        if (hit) begin
                            state   <= ST_CATCH;
                            esc_cnt <= '0;
                        end
                    end
                    ST_CATCH: begin
                        if (landed) begin
                            if (score != '1)
                                score <= score + 1'b1;
                            if (level == LAST_LEVEL) begin
                                state        <= ST_WIN;
                                win_pulse    <= 1'b1;
                                fish_visible <= 1'b0;
                            end else begin
                                level  <= level + 1'b1;
                                line_y <= SURF;
                                fish_y <= next_level_y;
                                fish_h <= next_level_h;
                                state  <= ST_FISH;
                            end
                        end else begin
                            fish_y <= (fish_y >= step_cw) ? fish_y - step_cw : '0;
                            line_y <= (line_y >= step_cw) ? line_y - step_cw : '0;
                            if (step != 3'd0) begin
                                esc_cnt <= '0;
                            end else if (esc_cnt == ESC_LAST) begin
                                state        <= ST_ESCAPE;
                                fish_visible <= 1'b0;
                            end else begin
                                esc_cnt <= esc_cnt + 1'b1;
                            end
                        end
                    end
                    ST_ESCAPE: begin
                        fish_y       <= cur_level_y;
                        line_y       <= SURF;
                        state        <= ST_FISH;
                        fish_visible <= 1'b1;
                    end
                    ST_WIN: begin
                        if (move_held) begin
                            level        <= '0;
                            line_y       <= SURF;
                            fish_y       <= CW'(FISH_Y0);
                            fish_h       <= CW'(fish_h_for_level(0));
                            state        <= ST_FISH;
                            fish_visible <= 1'b1;
                        end
                    end
                    default: state <= ST_FISH;
                endcase
            end
        end
    end

endmodule
